rx_cal_ctrl: RTL

Reader-to-tag preamble calibration controller for the tag receive path. It sequences a shared 10-bit interval counter across the Gen2 preamble: delimiter, data-0, RTcal, and optional TRcal. It latches the Tari, RTcal and TRcal lengths in clock cycles and derives the data-bit pivot. It sits between the demodulator output and the RX bit decoder and command parser, and tells the decoder whether a full preamble or only a frame-sync was received.

---
 rtl/rfid_rx_pkg.sv | 22 ++
 rtl/rx_interval_cnt.sv | 57 +++++
 rtl/rx_cal_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/rfid_rx_pkg.sv
// -----------------------------------------------------------------------------
// rfid_rx_pkg
// Shared definitions for the tag receive-path calibration logic.
//   RX_CNT_W      default interval counter / measurement width
//   RX_MAX_COUNT  default largest legal interval (larger counts are timeouts)
//   rx_cal_state_e  preamble sequencing states of rx_cal_ctrl
// -----------------------------------------------------------------------------
package rfid_rx_pkg;

   localparam int RX_CNT_W     = 10;
   localparam int RX_MAX_COUNT = 750;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_DELIM = 3'd1,
      DELIM      = 3'd2,
      DATA0      = 3'd3,
      RTCAL      = 3'd4,
      TRCAL_TEST = 3'd5
   } rx_cal_state_e;

endpackage

// File: rtl/rx_interval_cnt.sv
// -----------------------------------------------------------------------------
// rx_interval_cnt
// Saturating interval counter shared by all preamble measurements.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   clear       force the count to 0 (highest priority)
//   en          increment while measuring
//   rise        load 1; the count present in this cycle is the interval
//   count       current interval count
//   overflow    count > MAX_COUNT
// -----------------------------------------------------------------------------
module rx_interval_cnt
   import rfid_rx_pkg::*;
#(
   parameter int CNT_W     = RX_CNT_W,
   parameter int MAX_COUNT = RX_MAX_COUNT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             en,
   input  logic             rise,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Loading 1 on a rise makes the count seen at the next rise equal the
   // number of cycles between the two rises. Saturation stops at MAX_C+1 so
   // overflow stays asserted instead of wrapping.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (rise) begin
         count_d = CNT_W'(1);
      end else if (en && (count_q <= MAX_C)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count    = count_q;
   assign overflow = (count_q > MAX_C);

endmodule

// File: rtl/rx_cal_ctrl.sv
// -----------------------------------------------------------------------------
// rx_cal_ctrl
// Gen2 reader-to-tag preamble calibration: walks delimiter, data-0, RTcal and
// the optional TRcal, latching Tari/RTcal/TRcal in clock cycles and the
// data-bit pivot (RTcal/2).
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   enable       low forces IDLE on the next clock
//   demodin      synchronized envelope, low = reader pulse
//   tari, rtcal, trcal, pivot   latched calibration values
//   trcal_valid  last preamble carried TRcal
//   first_bit    frame-sync case: value of the bit consumed by the TRcal test
//   done         one-cycle strobe; the calibration set is complete and stable
//                in this cycle. There is no ready: consumers sample on done.
//   timeout      one-cycle strobe on an interval overflow
//   cal_err      RTcal outside [2*Tari, 4*Tari] (only with the macro below)
//   dbg_state    current FSM state, for debug and checkers
// Build option: define RXCAL_RATIO_CHECK_EN to build the RTcal/Tari ratio
// check; without it cal_err is constant 0.
// -----------------------------------------------------------------------------
module rx_cal_ctrl
   import rfid_rx_pkg::*;
#(
   parameter int CNT_W     = RX_CNT_W,
   parameter int MAX_COUNT = RX_MAX_COUNT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             demodin,
   output logic [CNT_W-1:0] tari,
   output logic [CNT_W-1:0] rtcal,
   output logic [CNT_W-1:0] trcal,
   output logic [CNT_W-1:0] pivot,
   output logic             trcal_valid,
   output logic             first_bit,
   output logic             done,
   output logic             timeout,
   output logic             cal_err,
   output rx_cal_state_e    dbg_state
);

   rx_cal_state_e    state_q, state_d;
   logic [CNT_W-1:0] tari_q, tari_d;
   logic [CNT_W-1:0] rtcal_q, rtcal_d;
   logic [CNT_W-1:0] trcal_q, trcal_d;
   logic [CNT_W-1:0] pivot_q, pivot_d;
   logic             trcal_valid_q, trcal_valid_d;
   logic             first_bit_q, first_bit_d;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;
   logic             cal_err_q, cal_err_d;
   logic             demodin_q;

   logic             rise;
   logic             measuring;
   logic             cnt_clear;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic             ratio_bad;

   assign rise      = demodin & ~demodin_q;
   assign measuring = (state_q == DELIM) || (state_q == DATA0) ||
                      (state_q == RTCAL) || (state_q == TRCAL_TEST);
   // The counter sits at 0 while not measuring so DELIM starts from 0.
   assign cnt_clear = ~enable || (state_q == IDLE) || (state_q == WAIT_DELIM);

   rx_interval_cnt #(
      .CNT_W     (CNT_W),
      .MAX_COUNT (MAX_COUNT)
   ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .clear    (cnt_clear),
      .en       (measuring),
      .rise     (rise),
      .count    (count),
      .overflow (overflow)
   );

`ifdef RXCAL_RATIO_CHECK_EN
   // Two extra bits so 4*tari cannot overflow.
   logic [CNT_W+1:0] meas_x, tari_x2, tari_x4;
   assign meas_x    = {2'b00, count};
   assign tari_x2   = {1'b0, tari_q, 1'b0};
   assign tari_x4   = {tari_q, 2'b00};
   assign ratio_bad = (meas_x < tari_x2) || (meas_x > tari_x4);
`else
   assign ratio_bad = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      tari_d        = tari_q;
      rtcal_d       = rtcal_q;
      trcal_d       = trcal_q;
      pivot_d       = pivot_q;
      trcal_valid_d = trcal_valid_q;
      first_bit_d   = first_bit_q;
      cal_err_d     = cal_err_q;
      done_d        = 1'b0;
      timeout_d     = 1'b0;

      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:       state_d = WAIT_DELIM;
            WAIT_DELIM: if (!demodin) state_d = DELIM;
            DELIM:      if (rise) state_d = DATA0;
            DATA0: begin
               if (rise) begin
                  tari_d  = count;
                  state_d = RTCAL;
               end
            end
            RTCAL: begin
               if (rise) begin
                  rtcal_d   = count;
                  pivot_d   = count >> 1;
                  cal_err_d = ratio_bad;
                  state_d   = TRCAL_TEST;
               end
            end
            TRCAL_TEST: begin
               // An interval longer than RTcal can only be TRcal; otherwise it
               // was the first data bit of a frame-sync and is decoded here.
               if (rise) begin
                  if (count > rtcal_q) begin
                     trcal_d       = count;
                     trcal_valid_d = 1'b1;
                     first_bit_d   = 1'b0;
                  end else begin
                     trcal_d       = '0;
                     trcal_valid_d = 1'b0;
                     first_bit_d   = (count > pivot_q);
                  end
                  done_d  = 1'b1;
                  state_d = WAIT_DELIM;
               end
            end
            default:    state_d = IDLE;
         endcase

         // A rise in the overflow cycle still counts as a valid edge.
         if (measuring && !rise && overflow) begin
            timeout_d = 1'b1;
            state_d   = WAIT_DELIM;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         tari_q        <= '0;
         rtcal_q       <= '0;
         trcal_q       <= '0;
         pivot_q       <= '0;
         trcal_valid_q <= 1'b0;
         first_bit_q   <= 1'b0;
         done_q        <= 1'b0;
         timeout_q     <= 1'b0;
         cal_err_q     <= 1'b0;
         demodin_q     <= 1'b1;
      end else begin
         state_q       <= state_d;
         tari_q        <= tari_d;
         rtcal_q       <= rtcal_d;
         trcal_q       <= trcal_d;
         pivot_q       <= pivot_d;
         trcal_valid_q <= trcal_valid_d;
         first_bit_q   <= first_bit_d;
         done_q        <= done_d;
         timeout_q     <= timeout_d;
         cal_err_q     <= cal_err_d;
         demodin_q     <= demodin;
      end
   end

   assign tari        = tari_q;
   assign rtcal       = rtcal_q;
   assign trcal       = trcal_q;
   assign pivot       = pivot_q;
   assign trcal_valid = trcal_valid_q;
   assign first_bit   = first_bit_q;
   assign done        = done_q;
   assign timeout     = timeout_q;
   assign cal_err     = cal_err_q;
   assign dbg_state   = state_q;

endmodule
